// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the systolic array: host-loaded imem, FETCH/EXEC FSM, timed strobes.
// Optional hardware LOOP instruction enabled by defining TPU_SEQ_LOOP_EN.
module tpu_sequencer #(
  parameter int INSTR_W        = 16,
  parameter int IMEM_DEPTH     = 8,
  parameter int PC_W           = $clog2(IMEM_DEPTH),
  parameter int COMPUTE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-4:0] base_address,
  output logic               load_weight,
  output logic               load_input,
  output logic               valid,
  output logic               store,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int OP_W = INSTR_W - 3;
  localparam logic [2:0] OP_HALT = 3'b000, OP_LOAD_ADDR = 3'b001, OP_LOAD_WEIGHT = 3'b010,
                         OP_LOAD_INPUTS = 3'b011, OP_COMPUTE = 3'b100, OP_STORE = 3'b101,
                         OP_LOOP = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t              state, next_state;
  logic [INSTR_W-1:0]  imem [IMEM_DEPTH];
  logic [INSTR_W-1:0]  instr, fetched;
  logic [PC_W-1:0]     pc, next_pc;
  logic [OP_W-1:0]     cycle_cnt, operand, f_operand, compute_len;
  logic [2:0]          op, f_op;
  logic                idle_like, exec_last, last_pc, illegal, abnormal, prog_end;
  logic                loop_taken, loop_fault;
  logic                lw_next, li_next, st_next, valid_next;

  assign fetched     = imem[pc];
  assign f_op        = fetched[INSTR_W-1 -: 3];
  assign f_operand   = fetched[OP_W-1:0];
  assign op          = instr[INSTR_W-1 -: 3];
  assign operand     = instr[OP_W-1:0];
  assign compute_len = (f_operand == '0) ? OP_W'(COMPUTE_CYCLES) : f_operand;
  assign idle_like   = (state == S_IDLE) || (state == S_DONE);
  assign exec_last   = (state == S_EXEC) && !((op == OP_COMPUTE) && (cycle_cnt != '0));
  assign last_pc     = (pc == PC_W'(IMEM_DEPTH - 1));

`ifdef TPU_SEQ_LOOP_EN
  logic [OP_W-PC_W-1:0] loop_cnt, loop_dec, loop_k;
  logic [PC_W-1:0]      loop_pc, loop_target;
  logic                 loop_active, is_loop;

  assign is_loop     = (op == OP_LOOP);
  assign loop_k      = operand[OP_W-1:PC_W];
  assign loop_target = operand[PC_W-1:0];
  assign loop_dec    = loop_cnt - 1'b1;
  // Only the LOOP that opened the active loop may close it; any other LOOP is a nesting fault.
  assign loop_fault  = is_loop && loop_active && (pc != loop_pc);
  assign loop_taken  = is_loop && !loop_fault &&
                       (loop_active ? (loop_dec != '0) : (loop_k != '0));
  assign illegal     = (op == 3'b111);
  assign next_pc     = loop_taken ? loop_target : pc + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_cnt    <= '0;
      loop_active <= 1'b0;
      loop_pc     <= '0;
    end else if (idle_like && start) begin
      loop_active <= 1'b0;
    end else if ((state == S_EXEC) && is_loop && !loop_fault) begin
      if (!loop_active) begin
        loop_cnt    <= loop_k;
        loop_active <= (loop_k != '0);
        loop_pc     <= pc;
      end else begin
        loop_cnt    <= loop_dec;
        loop_active <= (loop_dec != '0);
      end
    end
  end
`else
  assign loop_taken = 1'b0;
  assign loop_fault = 1'b0;
  assign illegal    = (op == 3'b111) || (op == OP_LOOP);
  assign next_pc    = pc + 1'b1;
`endif

  assign abnormal = illegal || loop_fault || (last_pc && (op != OP_HALT) && !loop_taken);
  assign prog_end = (op == OP_HALT) || abnormal;

  always_ff @(posedge clk) begin
    if (imem_we && idle_like)
      imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: next_state = S_EXEC;
      S_EXEC:  if (exec_last) next_state = prog_end ? S_DONE : S_FETCH;
      S_DONE:  if (start) next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobe next-values are decoded one cycle early so the registered strobes line up with EXEC.
  always_comb begin
    lw_next    = (state == S_FETCH) && (f_op == OP_LOAD_WEIGHT);
    li_next    = (state == S_FETCH) && (f_op == OP_LOAD_INPUTS);
    st_next    = (state == S_FETCH) && (f_op == OP_STORE);
    valid_next = ((state == S_FETCH) && (f_op == OP_COMPUTE)) ||
                 ((state == S_EXEC) && (op == OP_COMPUTE) && (cycle_cnt != '0));
    busy       = (state == S_FETCH) || (state == S_EXEC);
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= '0;
      instr        <= '0;
      cycle_cnt    <= '0;
      base_address <= '0;
      err          <= 1'b0;
      load_weight  <= 1'b0;
      load_input   <= 1'b0;
      store        <= 1'b0;
      valid        <= 1'b0;
    end else begin
      load_weight <= lw_next;
      load_input  <= li_next;
      store       <= st_next;
      valid       <= valid_next;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          pc  <= '0;
          err <= 1'b0;
        end
        S_FETCH: begin
          instr <= fetched;
          if (f_op == OP_COMPUTE) cycle_cnt <= compute_len - 1'b1;
        end
        S_EXEC: begin
          if (op == OP_LOAD_ADDR) base_address <= operand;
          if (!exec_last)    cycle_cnt <= cycle_cnt - 1'b1;
          else if (prog_end) err       <= abnormal;
          else               pc        <= next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed, table-driven bench for tpu_sequencer: whole-program vectors plus multi-cycle corner cases.
module tb_tpu_sequencer;

  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [2:0]  imem_waddr = '0;
  logic [15:0] imem_wdata = '0;
  logic [12:0] base_address;
  logic        load_weight, load_input, valid, store, busy, done, err;

  int total = 0;
  int bad = 0;

  tpu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .base_address(base_address),
    .load_weight(load_weight), .load_input(load_input), .valid(valid), .store(store),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [7:0][15:0]  prog;
    int                lw, li, st, vcyc, vrun, cycles;
    int                base, err_exp;
  } vec_t;

  typedef struct {
    int lw, li, st, vcyc, vrun, cycles, first_busy, first_err, err_end, base;
  } res_t;

  function automatic logic [15:0] ins(input logic [2:0] op, input int operand);
    return {op, 13'(operand)};
  endfunction

  function automatic logic [7:0][15:0] p8(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic write_prog(input logic [7:0][15:0] prog);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = 3'(i);
      imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  // wr_at: -1 none, 0 write together with start, >0 write plus extra start pulse at that cycle.
  task automatic apply_stimulus(input int wr_at, input logic [2:0] wa, input logic [15:0] wd,
                                output res_t r);
    int run;
    r = '{default: 0};
    r.cycles = -1;
    run = 0;
    @(negedge clk);
    start = 1'b1;
    if (wr_at == 0) begin imem_we = 1'b1; imem_waddr = wa; imem_wdata = wd; end
    @(posedge clk);
    #1;
    start   = 1'b0;
    imem_we = 1'b0;
    r.first_busy = int'(busy);
    r.first_err  = int'(err);
    for (int c = 1; c <= BUDGET; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
        start   = 1'b0;
        imem_we = 1'b0;
      end
      r.lw += int'(load_weight);
      r.li += int'(load_input);
      r.st += int'(store);
      if (valid) begin
        r.vcyc++;
        run++;
        if (run > r.vrun) r.vrun = run;
      end else run = 0;
      if (done) begin
        r.cycles = c;
        break;
      end
      if (c == wr_at) begin
        imem_we = 1'b1; imem_waddr = wa; imem_wdata = wd; start = 1'b1;
      end
    end
    r.err_end = int'(err);
    r.base    = int'(base_address);
    if (r.cycles < 0) $display("[TB] FAIL timeout: got no done within %0d cycles expected done", BUDGET);
  endtask

  vec_t  vecs[7];
  res_t  r;
  logic [15:0] HLT, LW, LI, ST, ILL;

  initial begin
    HLT = ins(3'b000, 0); LW = ins(3'b010, 0); LI = ins(3'b011, 0);
    ST  = ins(3'b101, 0); ILL = ins(3'b111, 0);

    vecs[0] = '{"basic", p8(ins(3'b001, 5), LW, LI, ins(3'b100, 0), ST, HLT, HLT, HLT),
                1, 1, 1, 4, 4, 16, 5, 0};
    vecs[1] = '{"compute7", p8(ins(3'b100, 7), HLT, HLT, HLT, HLT, HLT, HLT, HLT),
                0, 0, 0, 7, 7, 11, 5, 0};
    vecs[2] = '{"overflow", p8(LW, LW, LW, LW, LW, LW, LW, LW),
                8, 0, 0, 0, 0, 17, 5, 1};
    vecs[3] = '{"illegal", p8(LW, LI, ILL, ST, ST, ST, ST, ST),
                1, 1, 0, 0, 0, 7, 5, 1};
    vecs[4] = '{"maxaddr", p8(ins(3'b001, 13'h1FFF), ins(3'b100, 1), ST, HLT, HLT, HLT, HLT, HLT),
                0, 0, 1, 1, 1, 9, 13'h1FFF, 0};
    vecs[5] = '{"halt_last", p8(LI, LI, LI, LI, LI, LI, LI, HLT),
                0, 7, 0, 0, 0, 17, 13'h1FFF, 0};
`ifdef TPU_SEQ_LOOP_EN
    vecs[6] = '{"loop", p8(LW, ins(3'b110, 16), HLT, HLT, HLT, HLT, HLT, HLT),
                3, 0, 0, 0, 0, 15, 13'h1FFF, 0};
`else
    vecs[6] = '{"loop", p8(LW, ins(3'b110, 16), HLT, HLT, HLT, HLT, HLT, HLT),
                1, 0, 0, 0, 0, 5, 13'h1FFF, 1};
`endif

    #12;
    check_output("reset_outputs",
                 int'({base_address, load_weight, load_input, valid, store, busy, done, err}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      write_prog(vecs[i].prog);
      apply_stimulus(-1, 3'd0, 16'd0, r);
      check_output({vecs[i].name, "_lw"},     r.lw,      vecs[i].lw);
      check_output({vecs[i].name, "_li"},     r.li,      vecs[i].li);
      check_output({vecs[i].name, "_st"},     r.st,      vecs[i].st);
      check_output({vecs[i].name, "_vcyc"},   r.vcyc,    vecs[i].vcyc);
      check_output({vecs[i].name, "_vrun"},   r.vrun,    vecs[i].vrun);
      check_output({vecs[i].name, "_cycles"}, r.cycles,  vecs[i].cycles);
      check_output({vecs[i].name, "_base"},   r.base,    vecs[i].base);
      check_output({vecs[i].name, "_err"},    r.err_end, vecs[i].err_exp);
      check_output({vecs[i].name, "_busy1"},  r.first_busy, 1);
    end

    // Restart from an errored DONE: err clears and busy rises on the first cycle.
    write_prog(vecs[3].prog);
    apply_stimulus(-1, 3'd0, 16'd0, r);
    check_output("pre_restart_err", r.err_end, 1);
    apply_stimulus(-1, 3'd0, 16'd0, r);
    check_output("restart_busy", r.first_busy, 1);
    check_output("restart_err_cleared", r.first_err, 0);
    check_output("restart_cycles", r.cycles, 7);

    // Write and start in the same cycle: the fetch at pc 0 must see the new HALT.
    write_prog(p8(LW, LW, LW, LW, LW, LW, LW, LW));
    apply_stimulus(0, 3'd0, HLT, r);
    check_output("wr_start_cycles", r.cycles, 3);
    check_output("wr_start_lw", r.lw, 0);
    check_output("wr_start_err", r.err_end, 0);

    // Writes and start pulses while busy are ignored.
    write_prog(vecs[1].prog);
    apply_stimulus(3, 3'd1, ILL, r);
    check_output("busy_ignore_cycles", r.cycles, 11);
    check_output("busy_ignore_err", r.err_end, 0);
    check_output("busy_ignore_vcyc", r.vcyc, 7);

    // Asynchronous reset while valid is high.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 10 && !valid; c++) begin
      @(posedge clk);
      #1;
    end
    check_output("mid_valid_high", int'(valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_valid", int'(valid), 0);
    check_output("async_busy_done", int'({busy, done, err}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(-1, 3'd0, 16'd0, r);
    check_output("after_reset_cycles", r.cycles, 11);
    check_output("after_reset_vcyc", r.vcyc, 7);
    check_output("after_reset_base", r.base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
